// File: rtl/thermometer_codec_seq.sv
// Handshaked thermometer codec: one-cycle encode of a K-bit value, or a
// bit-serial LSB-first decode of a W-bit thermometer code with bubble flagging.
module thermometer_codec_seq #(
    parameter int K = 5,
    parameter int W = (1 << K) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [K-1:0] in_bin,
    input  logic [W-1:0] in_therm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] out_bin,
    output logic [W-1:0] out_therm,
    output logic         out_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   shift_reg;
    logic [K-1:0]   idx;
    logic [K-1:0]   count;
    logic           seen_zero;
    logic           err;
    logic           scan_bit;
    logic           last_bit;
    logic [K-1:0]   count_next;
    logic           err_next;

    // Computed one bit wider so that n = W still yields all ones.
    function automatic logic [W-1:0] to_therm(input logic [K-1:0] n);
        logic [W:0] pow;
        pow = (W+1)'(1) << n;
        return W'(pow - (W+1)'(1));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = mode ? SCAN : DONE;
            end
            SCAN: begin
                if (last_bit)
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Once a zero has been seen, further ones are bubbles and no longer counted.
    always_comb begin
        scan_bit   = shift_reg[0];
        last_bit   = (idx == K'(W - 1));
        count_next = (scan_bit && !seen_zero) ? count + K'(1) : count;
        err_next   = err | (scan_bit & seen_zero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            idx       <= '0;
            count     <= '0;
            seen_zero <= 1'b0;
            err       <= 1'b0;
            out_bin   <= '0;
            out_therm <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !mode) begin
                        out_bin   <= in_bin;
                        out_therm <= to_therm(in_bin);
                        out_err   <= 1'b0;
                    end else if (in_valid && mode) begin
                        shift_reg <= in_therm;
                        idx       <= '0;
                        count     <= '0;
                        seen_zero <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                SCAN: begin
                    shift_reg <= shift_reg >> 1;
                    idx       <= idx + K'(1);
                    count     <= count_next;
                    err       <= err_next;
                    if (!scan_bit)
                        seen_zero <= 1'b1;
                    if (last_bit) begin
                        out_bin   <= count_next;
                        out_therm <= to_therm(count_next);
                        out_err   <= err_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_thermometer_codec_seq.sv
// Directed self-checking bench for thermometer_codec_seq at K=5 and K=3.
module tb_thermometer_codec_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [4:0]  in_bin;
    logic [30:0] in_therm;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_bin;
    logic [30:0] out_therm;
    logic        out_err;

    logic        d3_in_valid;
    logic        d3_in_ready;
    logic        d3_mode;
    logic [2:0]  d3_in_bin;
    logic [6:0]  d3_in_therm;
    logic        d3_out_valid;
    logic        d3_out_ready;
    logic [2:0]  d3_out_bin;
    logic [6:0]  d3_out_therm;
    logic        d3_out_err;

    int checks;
    int errors;

    thermometer_codec_seq #(.K(5), .W(31)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_bin    (in_bin),
        .in_therm  (in_therm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_therm (out_therm),
        .out_err   (out_err)
    );

    thermometer_codec_seq #(.K(3), .W(7)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .mode      (d3_mode),
        .in_bin    (d3_in_bin),
        .in_therm  (d3_in_therm),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .out_bin   (d3_out_bin),
        .out_therm (d3_out_therm),
        .out_err   (d3_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where out_valid is seen.
    // lat counts rising edges after the acceptance edge.
    task automatic applyStimulus(input logic m, input logic [4:0] b, input logic [30:0] t,
                                 output int lat, output logic [4:0] ob,
                                 output logic [30:0] ot, output logic oe);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        mode     = m;
        in_bin   = b;
        in_therm = t;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ob = out_bin;
        ot = out_therm;
        oe = out_err;
    endtask

    task automatic applyStimulus3(input logic m, input logic [2:0] b, input logic [6:0] t,
                                  output int lat, output logic [2:0] ob,
                                  output logic [6:0] ot, output logic oe);
        int guard;
        guard = 0;
        while (!d3_in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("k3_in_ready_before_req", {31'd0, d3_in_ready}, 32'd1);
        d3_mode     = m;
        d3_in_bin   = b;
        d3_in_therm = t;
        d3_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d3_in_valid = 1'b0;
        lat = 0;
        while (!d3_out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ob = d3_out_bin;
        ot = d3_out_therm;
        oe = d3_out_err;
    endtask

    initial begin
        int          lat;
        int          stale;
        logic [4:0]  ob;
        logic [30:0] ot;
        logic        oe;
        logic [2:0]  ob3;
        logic [6:0]  ot3;
        logic        oe3;
        logic [31:0] pow;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        mode         = 1'b0;
        in_bin       = '0;
        in_therm     = '0;
        out_ready    = 1'b1;
        d3_in_valid  = 1'b0;
        d3_mode      = 1'b0;
        d3_in_bin    = '0;
        d3_in_therm  = '0;
        d3_out_ready = 1'b1;

        #12;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_bin", {27'd0, out_bin}, 32'd0);
        checkOutput("rst_out_therm", {1'b0, out_therm}, 32'd0);
        checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] encode vectors");
        applyStimulus(1'b0, 5'd5, '0, lat, ob, ot, oe);
        checkOutput("enc5_lat", lat, 0);
        checkOutput("enc5_bin", {27'd0, ob}, 32'd5);
        checkOutput("enc5_therm", {1'b0, ot}, 32'h0000001F);
        checkOutput("enc5_err", {31'd0, oe}, 32'd0);
        applyStimulus(1'b0, 5'd0, '0, lat, ob, ot, oe);
        checkOutput("enc0_therm", {1'b0, ot}, 32'h0);
        checkOutput("enc0_bin", {27'd0, ob}, 32'd0);
        applyStimulus(1'b0, 5'd31, '0, lat, ob, ot, oe);
        checkOutput("enc31_therm", {1'b0, ot}, 32'h7FFFFFFF);
        checkOutput("enc31_bin", {27'd0, ob}, 32'd31);

        $display("[TB] decode vectors");
        applyStimulus(1'b1, '0, 31'h000000FF, lat, ob, ot, oe);
        checkOutput("dec_ff_lat", lat, 31);
        checkOutput("dec_ff_bin", {27'd0, ob}, 32'd8);
        checkOutput("dec_ff_therm", {1'b0, ot}, 32'hFF);
        checkOutput("dec_ff_err", {31'd0, oe}, 32'd0);
        applyStimulus(1'b1, '0, 31'h0, lat, ob, ot, oe);
        checkOutput("dec_0_bin", {27'd0, ob}, 32'd0);
        checkOutput("dec_0_therm", {1'b0, ot}, 32'h0);
        checkOutput("dec_0_err", {31'd0, oe}, 32'd0);
        applyStimulus(1'b1, '0, 31'h7FFFFFFF, lat, ob, ot, oe);
        checkOutput("dec_full_bin", {27'd0, ob}, 32'd31);
        checkOutput("dec_full_therm", {1'b0, ot}, 32'h7FFFFFFF);
        checkOutput("dec_full_err", {31'd0, oe}, 32'd0);
        applyStimulus(1'b1, '0, 31'h0000000B, lat, ob, ot, oe);
        checkOutput("dec_b_bin", {27'd0, ob}, 32'd2);
        checkOutput("dec_b_therm", {1'b0, ot}, 32'h3);
        checkOutput("dec_b_err", {31'd0, oe}, 32'd1);
        applyStimulus(1'b1, '0, 31'h40000000, lat, ob, ot, oe);
        checkOutput("dec_top_bin", {27'd0, ob}, 32'd0);
        checkOutput("dec_top_therm", {1'b0, ot}, 32'h0);
        checkOutput("dec_top_err", {31'd0, oe}, 32'd1);

        $display("[TB] backpressure");
        @(negedge clk);
        out_ready = 1'b0;
        mode      = 1'b0;
        in_bin    = 5'd9;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_bin = 5'd3;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_out_bin", {27'd0, out_bin}, 32'd9);
            checkOutput("bp_out_therm", {1'b0, out_therm}, 32'h1FF);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready_after_hs", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_valid_after_hs", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_next_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_next_bin", {27'd0, out_bin}, 32'd3);
        checkOutput("bp_next_therm", {1'b0, out_therm}, 32'h7);

        $display("[TB] reset mid-scan");
        applyStimulus(1'b0, 5'd5, '0, lat, ob, ot, oe);
        @(negedge clk);
        mode     = 1'b1;
        in_therm = 31'h0000FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_out_bin", {27'd0, out_bin}, 32'd0);
        checkOutput("midrst_out_therm", {1'b0, out_therm}, 32'd0);
        checkOutput("midrst_out_err", {31'd0, out_err}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid)
                stale++;
        end
        checkOutput("no_stale_result", stale, 0);
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] round trip K=5");
        for (int v = 0; v < 32; v++) begin
            pow = (32'd1 << v) - 32'd1;
            applyStimulus(1'b0, 5'(v), '0, lat, ob, ot, oe);
            checkOutput("rt5_enc_therm", {1'b0, ot}, pow);
            applyStimulus(1'b1, '0, ot, lat, ob, ot, oe);
            checkOutput("rt5_dec_bin", {27'd0, ob}, 32'(v));
            checkOutput("rt5_dec_err", {31'd0, oe}, 32'd0);
            checkOutput("rt5_dec_lat", lat, 31);
        end

        $display("[TB] round trip K=3");
        for (int v = 0; v < 8; v++) begin
            pow = (32'd1 << v) - 32'd1;
            applyStimulus3(1'b0, 3'(v), '0, lat, ob3, ot3, oe3);
            checkOutput("rt3_enc_therm", {25'd0, ot3}, pow);
            checkOutput("rt3_enc_lat", lat, 0);
            applyStimulus3(1'b1, '0, ot3, lat, ob3, ot3, oe3);
            checkOutput("rt3_dec_bin", {29'd0, ob3}, 32'(v));
            checkOutput("rt3_dec_err", {31'd0, oe3}, 32'd0);
            checkOutput("rt3_dec_lat", lat, 7);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
